// File: rtl/neuron_mac_if.sv
// Handshake bundle between the MAC stage, its upstream pair source and the
// downstream activation stage.
interface neuron_mac_if #(
  parameter int SIZE = 16
);
  logic            in_valid;
  logic            in_ready;
  logic [SIZE-1:0] x;
  logic [SIZE-1:0] w;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [SIZE-1:0] out_data;

  modport master (
    output in_valid, x, w, in_last, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, x, w, in_last, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/neuron_mac.sv
// Sign-magnitude multiply-accumulate for one neuron: multiplies each
// (input, weight) pair in a registered first stage, accumulates the products
// with saturating sign-magnitude addition in a second stage, and hands the
// finished sum downstream over a valid/ready handshake.
module neuron_mac #(
  parameter int SIZE = 16,
  parameter int FRAC = 8
) (
  input logic         clk,
  input logic         rst,
  neuron_mac_if.slave bus
);

  localparam int MAG = SIZE - 1;
  localparam logic [MAG-1:0] MAG_MAX = '1;

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_OUT
  } state_e;

  state_e state_q, state_d;

  logic [2*MAG-1:0] prodFull;
  logic [2*MAG-1:0] prodShift;
  logic [MAG-1:0]   prodMag;
  logic             prodSign;

  logic [MAG-1:0]   pMag_q;
  logic             pSign_q;
  logic             pValid_q;
  logic             pLast_q;

  logic [MAG-1:0]   accMag_q;
  logic             accSign_q;
  logic [MAG:0]     sameSum;
  logic [MAG-1:0]   sumMag;
  logic             sumSign;

  logic [SIZE-1:0]  outData_q;

  logic inReady;
  logic outValid;
  logic accept;
  logic lastAccum;
  logic handshake;

  assign accept    = bus.in_valid && inReady;
  assign lastAccum = pValid_q && pLast_q;
  assign handshake = outValid && bus.out_ready;

  // Magnitude product with the fractional shift; anything that spills past the
  // magnitude field clamps to full scale, and a zero product is always +0.
  always_comb begin
    prodFull  = {{MAG{1'b0}}, bus.x[MAG-1:0]} * {{MAG{1'b0}}, bus.w[MAG-1:0]};
    prodShift = prodFull >> FRAC;
    if (|prodShift[2*MAG-1:MAG]) begin
      prodMag = MAG_MAX;
    end else begin
      prodMag = prodShift[MAG-1:0];
    end
    prodSign = (bus.x[SIZE-1] ^ bus.w[SIZE-1]) & (|prodMag);
  end

  // Product pipeline register, loaded on every accepted pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pMag_q   <= '0;
      pSign_q  <= 1'b0;
      pValid_q <= 1'b0;
      pLast_q  <= 1'b0;
    end else begin
      pValid_q <= accept;
      if (accept) begin
        pMag_q  <= prodMag;
        pSign_q <= prodSign;
        pLast_q <= bus.in_last;
      end
    end
  end

  // Sign-magnitude sum of accumulator and product: add on matching signs with
  // saturation, otherwise subtract the smaller magnitude and keep the larger
  // one's sign; an exact cancellation collapses to +0.
  always_comb begin
    sameSum = {1'b0, accMag_q} + {1'b0, pMag_q};
    sumMag  = '0;
    sumSign = 1'b0;
    if (accSign_q == pSign_q) begin
      sumSign = accSign_q;
      sumMag  = sameSum[MAG] ? MAG_MAX : sameSum[MAG-1:0];
    end else if (accMag_q > pMag_q) begin
      sumSign = accSign_q;
      sumMag  = accMag_q - pMag_q;
    end else if (pMag_q > accMag_q) begin
      sumSign = pSign_q;
      sumMag  = pMag_q - accMag_q;
    end
  end

  // Accumulator and output register; the accumulator restarts at +0 once the
  // downstream stage has taken the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accMag_q  <= '0;
      accSign_q <= 1'b0;
      outData_q <= '0;
    end else begin
      if (handshake) begin
        accMag_q  <= '0;
        accSign_q <= 1'b0;
      end else if (pValid_q) begin
        accMag_q  <= sumMag;
        accSign_q <= sumSign;
      end
      if (lastAccum) begin
        outData_q <= {sumSign, sumMag};
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: stop taking pairs after the final term, wait for it to reach
  // the accumulator, then hold the result until it is consumed.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RUN:   if (accept && bus.in_last) state_d = S_DRAIN;
      S_DRAIN: if (lastAccum)             state_d = S_OUT;
      S_OUT:   if (handshake)             state_d = S_RUN;
      default:                            state_d = S_RUN;
    endcase
  end

  // Handshake outputs decoded from the registered state only, so out_ready
  // never reaches in_ready combinationally.
  always_comb begin
    inReady  = (state_q == S_RUN);
    outValid = (state_q == S_OUT);
  end

  assign bus.in_ready  = inReady;
  assign bus.out_valid = outValid;
  assign bus.out_data  = outData_q;

endmodule

// File: doc/neuron_mac.md
Name: neuron_mac

Overview:
- Sequential multiply-accumulate stage that feeds the sign-magnitude adder datapath. It forms one neuron's weighted sum from a stream of (input, weight) pairs.
- Values are sign-magnitude fixed point: MSB is the sign, the remaining SIZE-1 bits are magnitude with FRAC fractional bits.
- Each pair is multiplied and the product is accumulated with sign-magnitude addition. The finished sum goes out through a valid/ready handshake to the activation stage.

Parameters:
- SIZE, 16, total word width including the sign bit.
- FRAC, 8, fractional bits in the magnitude (1.0 = 1 << FRAC).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  x/w/in_last are valid this cycle.
- in_ready  output  1  stage can accept a pair.
- x  input  SIZE  sign-magnitude input activation.
- w  input  SIZE  sign-magnitude weight.
- in_last  input  1  this pair is the final term of the sum.
- out_valid  output  1  out_data holds a completed sum.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  SIZE  sign-magnitude weighted sum.

Behaviour:
- Reset (asynchronous, active-high, any state):
  - state = S_RUN; accumulator = +0; product register cleared; p_valid = 0.
  - in_ready = 1, out_valid = 0, out_data = 0.
  - A reset mid-vector discards all partial sums.
- Beat accept: a beat is accepted on an edge where in_valid && in_ready.
- Multiply (stage 1, registered on the accept edge):
  - product magnitude = (|x| * |w|) >> FRAC, truncated toward zero.
  - Full 2*(SIZE-1)-bit intermediate; if the shifted result exceeds 2^(SIZE-1)-1, saturate to 2^(SIZE-1)-1.
  - Product sign = x[SIZE-1] ^ w[SIZE-1], forced to 0 when product magnitude is 0.
  - p_valid and p_last are registered with the product.
- Accumulate (stage 2, edge after the product register is loaded, while p_valid):
  - Same signs: magnitude = acc + p.
  - Different signs: magnitude = larger - smaller, sign taken from the larger magnitude.
  - Equal magnitudes with opposite signs: result is +0 (sign 0). Negative zero is never stored or output.
  - Same-sign sum above 2^(SIZE-1)-1 saturates to 2^(SIZE-1)-1, keeping the sign. It never wraps.
- FSM states:
  - S_RUN: in_ready = 1. Accepting a beat with in_last = 1 moves to S_DRAIN.
  - S_DRAIN: in_ready = 0. On the edge that accumulates the last product, move to S_OUT, register out_data = final sum, set out_valid = 1.
  - S_OUT: in_ready = 0. out_data and out_valid are held stable while out_ready = 0. On out_valid && out_ready, clear out_valid and the accumulator to +0 and return to S_RUN; in_ready = 1 the next cycle.
- Latency: last pair accepted at edge E; out_valid is high starting the cycle after edge E+1, i.e. 2 edges later.
- Throughput: one pair per clock in S_RUN with no bubbles; back-to-back beats pipeline through the product register.
- Vector length: a single-beat vector (in_last on the first beat) is legal; result = that product.
- No combinational path from out_ready to in_ready.

Test Plan:
1. Reset, then x=0x0200, w=0x8180 (2.0 * -1.5) followed by x=0x0100, w=0x0100, in_last=1, out_ready=1 -> out_data=0x8200 (-2.0), out_valid exactly 2 edges after the last accept.
2. x=0x7FFF, w=0x7FFF, then the same pair with in_last=1 -> product saturates to 0x7FFF, sum saturates to out_data=0x7FFF.
3. x=0x0100, w=0x0100, then x=0x8100, w=0x0100, in_last=1 -> out_data=0x0000 (never 0x8000).
4. Completed sum with out_ready=0 for 5 cycles -> out_valid and out_data stable, in_ready=0 throughout; accumulator is +0 when the next vector starts after the handshake.
5. Assert rst mid-vector after 2 accepted beats, then send a fresh single-beat vector x=0x0300, w=0x0080 (3.0 * 0.5) -> out_data=0x0180, with no contribution from pre-reset beats.
6. Continuous in_valid=1 across two 3-beat vectors with out_ready=1 -> in_ready drops from the last accept until the handshake; each sum matches the golden model.
